// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller for a registered-output ALU.
// Accepts 12-bit register-register instructions (op, rd, rs, rt) over a
// valid/ready handshake, reads operands from an 8-entry register file, issues
// them to the external ALU, waits one clock for the registered result and
// writes it back, updating the carry/zero flags.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   instr_valid/instr_ready  instruction handshake; instr = {op, rd, rs, rt}
//   ext_we/ext_waddr/ext_wdata  register preload port (honoured in IDLE only)
//   dbg_raddr/dbg_rdata      combinational register file read port
//   alu_op/alu_a/alu_b/alu_cin  operands presented to the ALU
//   alu_r/alu_cout           ALU result, valid one clock after the operands
//   done/illegal             write-back pulse; illegal marks a rejected op=111
//   result/flag_c/flag_z     last written-back result and flags
module alu_op_sequencer #(
    parameter  int unsigned WIDTH   = 32,
    localparam int unsigned OP_W    = 3,
    localparam int unsigned RA_W    = 3,
    localparam int unsigned INSTR_W = OP_W + 3 * RA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    input  logic               ext_we,
    input  logic [RA_W-1:0]    ext_waddr,
    input  logic [WIDTH-1:0]   ext_wdata,
    input  logic [RA_W-1:0]    dbg_raddr,
    output logic [WIDTH-1:0]   dbg_rdata,
    output logic [OP_W-1:0]    alu_op,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_cin,
    input  logic [WIDTH-1:0]   alu_r,
    input  logic               alu_cout,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               flag_c,
    output logic               flag_z,
    output logic               illegal
);

    localparam int unsigned NREG = 8;

    localparam logic [OP_W-1:0] OP_MOV = 3'b000;
    localparam logic [OP_W-1:0] OP_NOT = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b011;
    localparam logic [OP_W-1:0] OP_ILL = 3'b111;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
    } instr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    state_t             state, state_next;
    instr_t             instr_q, instr_d;
    logic [WIDTH-1:0]   rf [NREG];

    logic [OP_W-1:0]    alu_op_d;
    logic [WIDTH-1:0]   alu_a_d, alu_b_d, result_d;
    logic               alu_cin_d, done_d, illegal_d, flag_c_d, flag_z_d, ready_d;
    logic               rf_we;
    logic [RA_W-1:0]    rf_waddr;
    logic [WIDTH-1:0]   rf_wdata;

    // Debug read; r0 is never written so it always reads zero.
    assign dbg_rdata = rf[dbg_raddr];

    // Next-state and next-register-value logic.
    always_comb begin
        state_next = state;
        instr_d    = instr_q;
        alu_op_d   = alu_op;
        alu_a_d    = alu_a;
        alu_b_d    = alu_b;
        alu_cin_d  = alu_cin;
        result_d   = result;
        flag_c_d   = flag_c;
        flag_z_d   = flag_z;
        done_d     = 1'b0;
        illegal_d  = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = ext_waddr;
        rf_wdata   = ext_wdata;

        unique case (state)
            S_IDLE: begin
                rf_we = ext_we;
                if (instr_valid) begin
                    instr_d    = instr_t'(instr);
                    state_next = S_READ;
                end
            end
            S_READ: begin
                alu_op_d   = instr_q.op;
                alu_a_d    = rf[instr_q.rs];
                alu_b_d    = (instr_q.op == OP_MOV || instr_q.op == OP_NOT) ? '0 : rf[instr_q.rt];
                alu_cin_d  = (instr_q.op == OP_SUB);
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_WB;
            end
            S_WB: begin
                if (instr_q.op != OP_ILL) begin
                    rf_we    = 1'b1;
                    rf_waddr = instr_q.rd;
                    rf_wdata = alu_r;
                    result_d = alu_r;
                    flag_z_d = (alu_r == '0);
                    if (instr_q.op == OP_ADD || instr_q.op == OP_SUB) begin
                        flag_c_d = alu_cout;
                    end
                end else begin
                    illegal_d = 1'b1;
                end
                done_d     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        ready_d = (state_next == S_IDLE);
    end

    // State, outputs and register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            instr_q     <= '0;
            instr_ready <= 1'b1;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_cin     <= 1'b0;
            result      <= '0;
            flag_c      <= 1'b0;
            flag_z      <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            state       <= state_next;
            instr_q     <= instr_d;
            instr_ready <= ready_d;
            alu_op      <= alu_op_d;
            alu_a       <= alu_a_d;
            alu_b       <= alu_b_d;
            alu_cin     <= alu_cin_d;
            result      <= result_d;
            flag_c      <= flag_c_d;
            flag_z      <= flag_z_d;
            done        <= done_d;
            illegal     <= illegal_d;
            // Writes to r0 are discarded.
            if (rf_we && rf_waddr != '0) begin
                rf[rf_waddr] <= rf_wdata;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: an external registered ALU, a behavioural
// model of the instruction set with a per-cycle compare process, and directed
// vectors with hand-computed expectations.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [11:0] instr;
    logic        instr_ready;
    logic        ext_we;
    logic [2:0]  ext_waddr;
    logic [31:0] ext_wdata;
    logic [2:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic        alu_cin;
    logic [31:0] alu_r;
    logic        alu_cout;
    logic        done;
    logic [31:0] result;
    logic        flag_c, flag_z, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .ext_we     (ext_we),
        .ext_waddr  (ext_waddr),
        .ext_wdata  (ext_wdata),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_r      (alu_r),
        .alu_cout   (alu_cout),
        .done       (done),
        .result     (result),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // External ALU with a registered result: SUB is a + ~b + cin.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_r    <= '0;
            alu_cout <= 1'b0;
        end else begin
            case (alu_op)
                3'd0: {alu_cout, alu_r} <= {1'b0, alu_a};
                3'd1: {alu_cout, alu_r} <= {1'b0, ~alu_a};
                3'd2: {alu_cout, alu_r} <= {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
                3'd3: {alu_cout, alu_r} <= {1'b0, alu_a} + {1'b0, ~alu_b} + {32'd0, alu_cin};
                3'd4: {alu_cout, alu_r} <= {1'b0, alu_a | alu_b};
                3'd5: {alu_cout, alu_r} <= {1'b0, alu_a & alu_b};
                3'd6: {alu_cout, alu_r} <= {1'b0, 31'd0, ($signed(alu_a) < $signed(alu_b))};
                default: {alu_cout, alu_r} <= 33'd0;
            endcase
        end
    end

    // Instruction-level meaning: {carry, value}; SUB carry means no borrow.
    function automatic logic [32:0] golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return {1'b0, a};
            3'd1:    return {1'b0, ~a};
            3'd2:    return {1'b0, a} + {1'b0, b};
            3'd3:    return {(a >= b), a - b};
            3'd4:    return {1'b0, a | b};
            3'd5:    return {1'b0, a & b};
            3'd6:    return ($signed(a) < $signed(b)) ? 33'd1 : 33'd0;
            default: return 33'd0;
        endcase
    endfunction

    // Model: one instruction in flight, retiring three edges after acceptance.
    logic [31:0] m_rf [8];
    logic        m_busy, m_done, m_ill, m_ready, m_c, m_z, e_cin;
    logic [31:0] m_result, e_a, e_b;
    logic [2:0]  e_op;
    logic [11:0] p_instr;
    int          cyc, acc;
    logic [32:0] m_g;

    assign m_g = golden(p_instr[11:9], m_rf[p_instr[5:3]], m_rf[p_instr[2:0]]);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_rf[i] <= '0;
            m_busy <= 1'b0; m_done <= 1'b0; m_ill <= 1'b0; m_ready <= 1'b1;
            m_c <= 1'b0; m_z <= 1'b0; m_result <= '0;
            e_op <= '0; e_a <= '0; e_b <= '0; e_cin <= 1'b0;
            p_instr <= '0; cyc <= 0; acc <= 0;
        end else begin
            m_done <= 1'b0;
            m_ill  <= 1'b0;
            cyc    <= cyc + 1;
            if (!m_busy) begin
                if (ext_we && ext_waddr != 3'd0) m_rf[ext_waddr] <= ext_wdata;
                if (instr_valid) begin
                    m_busy  <= 1'b1;
                    m_ready <= 1'b0;
                    acc     <= cyc;
                    p_instr <= instr;
                end
            end else if (cyc == acc + 1) begin
                e_op  <= p_instr[11:9];
                e_a   <= m_rf[p_instr[5:3]];
                e_b   <= (p_instr[11:9] <= 3'd1) ? 32'd0 : m_rf[p_instr[2:0]];
                e_cin <= (p_instr[11:9] == 3'd3);
            end else if (cyc == acc + 3) begin
                if (p_instr[11:9] != 3'd7) begin
                    if (p_instr[8:6] != 3'd0) m_rf[p_instr[8:6]] <= m_g[31:0];
                    m_result <= m_g[31:0];
                    m_z      <= (m_g[31:0] == 32'd0);
                    if (p_instr[11:9] == 3'd2 || p_instr[11:9] == 3'd3) m_c <= m_g[32];
                end else begin
                    m_ill <= 1'b1;
                end
                m_done  <= 1'b1;
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("instr_ready", {31'd0, instr_ready}, {31'd0, m_ready});
            check("done",        {31'd0, done},        {31'd0, m_done});
            check("illegal",     {31'd0, illegal},     {31'd0, m_ill});
            check("result",      result,               m_result);
            check("flag_c",      {31'd0, flag_c},      {31'd0, m_c});
            check("flag_z",      {31'd0, flag_z},      {31'd0, m_z});
            check("alu_op",      {29'd0, alu_op},      {29'd0, e_op});
            check("alu_a",       alu_a,                e_a);
            check("alu_b",       alu_b,                e_b);
            check("alu_cin",     {31'd0, alu_cin},     {31'd0, e_cin});
            check("dbg_rdata",   dbg_rdata,            m_rf[dbg_raddr]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ext_write(input logic [2:0] a, input logic [31:0] d);
        ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
        tick();
        ext_we = 1'b0;
    endtask

    // Offer an instruction, hold it until accepted; k = cycles spent not ready.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, output int k);
        k = 0;
        instr = {op, rd, rs, rt};
        instr_valid = 1'b1;
        while (!instr_ready && k < 20) begin
            tick();
            k++;
        end
        if (!instr_ready) check("accept_timeout", 32'd0, 32'd1);
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 10) begin
            tick();
            k++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt);
        int w, k;
        issue(op, rd, rs, rt, w);
        wait_done(k);
        check("latency", k, 32'd3);
    endtask

    task automatic peek(input logic [2:0] a, input logic [31:0] exp, input string name);
        dbg_raddr = a;
        #1;
        check(name, dbg_rdata, exp);
    endtask

    initial begin
        int w, k;
        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        ext_we = 1'b0; ext_waddr = '0; ext_wdata = '0; dbg_raddr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  {31'd0, instr_ready}, 32'd1);
        check("rst_done",   {31'd0, done},        32'd0);
        check("rst_result", result,               32'd0);
        check("rst_alu_a",  alu_a,                32'd0);
        rst = 1'b0;
        tick();

        // ADD without and with carry-out.
        ext_write(3'd1, 32'h0000_FFFF);
        ext_write(3'd2, 32'h0000_0001);
        run(3'd2, 3'd3, 3'd1, 3'd2);
        peek(3'd3, 32'h0001_0000, "add_r3");
        check("add_c", {31'd0, flag_c}, 32'd0);
        check("add_z", {31'd0, flag_z}, 32'd0);
        ext_write(3'd1, 32'hFFFF_FFFF);
        run(3'd2, 3'd4, 3'd1, 3'd2);
        peek(3'd4, 32'h0000_0000, "addc_r4");
        check("addc_c", {31'd0, flag_c}, 32'd1);
        check("addc_z", {31'd0, flag_z}, 32'd1);

        // SUB to zero, then a negative result.
        ext_write(3'd1, 32'd5);
        ext_write(3'd2, 32'd5);
        ext_write(3'd5, 32'd6);
        run(3'd3, 3'd3, 3'd1, 3'd2);
        peek(3'd3, 32'h0000_0000, "sub_r3");
        check("sub_z", {31'd0, flag_z}, 32'd1);
        run(3'd3, 3'd4, 3'd2, 3'd5);
        peek(3'd4, 32'hFFFF_FFFF, "sub_r4");
        check("sub2_z", {31'd0, flag_z}, 32'd0);

        // SLT signed comparisons.
        ext_write(3'd1, 32'hFFFF_FFFF);
        ext_write(3'd2, 32'h0000_0000);
        ext_write(3'd7, 32'h0000_0055);
        run(3'd6, 3'd6, 3'd1, 3'd2);
        peek(3'd6, 32'd1, "slt_neg_lt");
        run(3'd6, 3'd6, 3'd2, 3'd1);
        peek(3'd6, 32'd0, "slt_swapped");
        ext_write(3'd2, 32'hFFFF_FFFF);
        run(3'd6, 3'd7, 3'd1, 3'd2);
        peek(3'd7, 32'd0, "slt_equal");

        // Illegal op leaves r3, result and flags untouched.
        ext_write(3'd3, 32'h0000_1234);
        issue(3'd7, 3'd3, 3'd1, 3'd2, w);
        wait_done(k);
        check("ill_pulse",  {31'd0, illegal}, 32'd1);
        check("ill_result", result,           32'd0);
        check("ill_z",      {31'd0, flag_z},  32'd1);
        peek(3'd3, 32'h0000_1234, "ill_r3");

        // MOV into r0 is discarded, as is an external r0 write.
        run(3'd0, 3'd0, 3'd1, 3'd0);
        ext_write(3'd0, 32'hABCD_0000);
        peek(3'd0, 32'd0, "r0_zero");

        // Back-to-back dependent pair with held valid.
        ext_write(3'd2, 32'hF0F0_F0F0);
        issue(3'd0, 3'd1, 3'd2, 3'd0, w);
        issue(3'd1, 3'd3, 3'd1, 3'd0, w);
        check("ready_gap", w, 32'd3);
        wait_done(k);
        check("b2b_latency", k, 32'd3);
        peek(3'd3, 32'h0F0F_0F0F, "not_r3");

        // External write during EXEC is ignored.
        issue(3'd2, 3'd5, 3'd1, 3'd3, w);
        tick();
        ext_write(3'd6, 32'h0000_DEAD);
        wait_done(k);
        peek(3'd6, 32'd0, "exec_ext_ignored");
        peek(3'd5, 32'hFFFF_FFFF, "add_r5");

        // Reset during EXEC aborts the instruction.
        ext_write(3'd3, 32'h0000_0000);
        issue(3'd2, 3'd3, 3'd1, 3'd2, w);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("abort_done",   {31'd0, done},        32'd0);
        check("abort_ready",  {31'd0, instr_ready}, 32'd1);
        check("abort_alu_a",  alu_a,                32'd0);
        check("abort_result", result,               32'd0);
        check("abort_c",      {31'd0, flag_c},      32'd0);
        peek(3'd1, 32'd0, "abort_r1");
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, instr_ready}, 32'd1);
        check("post_rst_done",  {31'd0, done},        32'd0);
        peek(3'd3, 32'd0, "abort_r3");
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle controller that sequences a registered-output N-bit ALU. It accepts 12-bit register-register instructions over a valid/ready handshake and reads two operands from an internal 8-entry register file. It issues them to the ALU, waits for the registered result and writes it back. It sits between an instruction source (testbench or fetch logic) and the ALU datapath, and owns the register file and the carry/zero flags.

## Interface
- WIDTH, 32, datapath width of registers, ALU operands and result.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr  in  12  op[11:9], rd[8:6], rs[5:3], rt[2:0].
- instr_ready  out  1  sequencer can accept an instruction.
- ext_we  in  1  external register write strobe, used to preload registers.
- ext_waddr  in  3  external write address.
- ext_wdata  in  WIDTH  external write data.
- dbg_raddr  in  3  debug read address.
- dbg_rdata  out  WIDTH  combinational read of register dbg_raddr.
- alu_op  out  3  ALU opcode.
- alu_a  out  WIDTH  ALU operand A (R2).
- alu_b  out  WIDTH  ALU operand B (R3).
- alu_cin  out  1  ALU carry-in.
- alu_r  in  WIDTH  ALU result. The ALU registers it, so it is valid one clock after operands are presented.
- alu_cout  in  1  ALU carry-out, same timing as alu_r.
- done  out  1  one-cycle pulse at write-back.
- result  out  WIDTH  last written-back result, held until the next done.
- flag_c  out  1  carry flag.
- flag_z  out  1  zero flag.
- illegal  out  1  with done, indicates that op=111 was rejected.

## Operation
- Opcodes: 000 MOV (rs), 001 NOT (rs), 010 ADD, 011 SUB (rs−rt), 100 OR, 101 AND, 110 SLT (signed, result 1 or 0), 111 illegal.
- Register file: 8 × WIDTH.
  - r0 reads as 0. Writes to r0 are discarded, both from write-back and from ext_we.
- FSM states: IDLE → READ → EXEC → WB → IDLE.
- IDLE
  - instr_ready=1.
  - On instr_valid, latch instr and go to READ. Otherwise stay in IDLE.
- READ
  - Register alu_a←reg[rs] and alu_b←reg[rt]. For MOV and NOT, alu_b←0.
  - Register alu_op←op and alu_cin←(op==011).
  - Go to EXEC.
- EXEC: the ALU captures the operands on this edge. Go to WB.
- WB
  - If op≠111: reg[rd]←alu_r, result←alu_r, flag_z←(alu_r==0). For ADD/SUB only, flag_c←alu_cout; other ops leave flag_c unchanged.
  - If op==111: no register write, result and flags unchanged, illegal=1.
  - In both cases pulse done and go to IDLE.
- ext_we is honoured only in IDLE and ignored in all other states.
  - An ext_we and an instruction accepted in the same IDLE cycle are both performed.
  - READ then sees the new value (ext write precedes operand read).
- Arithmetic is modulo 2^WIDTH. Overflow is not flagged.
- alu_op, alu_a, alu_b and alu_cin hold their values from READ until the next READ.

## Timing
- Handshake: the transfer occurs on the rising edge where instr_valid && instr_ready. instr_ready is a function of state only, with no combinational path from instr_valid.
- Latency: instruction accepted on edge N, operands driven after N+1, done high after edge N+3. Write-back is visible on dbg_rdata after N+3.
- Throughput: one instruction per 4 cycles. The next accept can occur on edge N+4, in the cycle done is high.
- Reset values (asynchronous, applied immediately on rst):
  - state=IDLE, instr_ready=1.
  - All registers, alu_a, alu_b, alu_op, alu_cin, result, flag_c, flag_z, done and illegal are 0.
- Reset mid-operation aborts the instruction: no write-back and no done.
- instr_valid asserted while not ready: no effect. The source must hold it.
- A dependent instruction (rs==previous rd) needs no hazard logic, because write-back completes before the next READ.

## Test plan
- Preload r1=0x0000FFFF, r2=0x00000001 via ext_we. ADD r3,r1,r2 → done 3 cycles after accept, r3=0x00010000, flag_c=0, flag_z=0.
- Preload r1=r2=5. SUB r3,r1,r2 → r3=0, flag_z=1. Then SUB r4,r2,r5 with r5=6 → r4=0xFFFFFFFF, flag_z=0.
- SLT cases:
  - r1=0xFFFFFFFF, r2=0 → rd=1.
  - Swapped operands → rd=0.
  - Equal operands 0xFFFFFFFF → rd=0.
- op=111 with rd=3 → done with illegal=1, r3 and flags unchanged. MOV r0,r1 → dbg r0 still reads 0.
- Back-to-back:
  - MOV r1,r2 (r2=0xF0F0F0F0), then NOT r3,r1 → r3=0x0F0F0F0F.
  - instr_ready=0 for 3 cycles between accepts.
  - ext_we during EXEC is ignored.
- Assert rst in EXEC of ADD r3,r1,r2 → no done, r3=0, all outputs reset. After release, instr_ready=1 in the next cycle.
